// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART echo checker: FSM state enums, LFSR taps,
// baud divider and saturating-count helpers.
package uart_pkg;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic int unsigned clks_per_bit(int unsigned clk_freq, int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic logic [15:0] sat_inc16(logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Fibonacci step for x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_next(logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/uart_echo_checker_if.sv
// Serial link, run control and status bundle of the UART echo checker.
interface uart_echo_checker_if;
    logic        en;
    logic        serial_rx;
    logic        serial_tx;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic [15:0] err_count;
    logic [7:0]  last_exp;
    logic [7:0]  last_got;
    logic        timeout;

    modport master (
        input  en, serial_rx,
        output serial_tx, tx_count, rx_count, err_count, last_exp, last_got, timeout
    );

    modport slave (
        output en, serial_rx,
        input  serial_tx, tx_count, rx_count, err_count, last_exp, last_got, timeout
    );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with advance strobe and a synchronous load for resynchronisation.
module lfsr8
    import uart_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       sresetn,
    input  logic       advance,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] value
);

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            value <= SEED;
        end else if (load) begin
            value <= load_value;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/uart_echo_checker.sv
// UART traffic source and echo checker: sends an LFSR byte stream, checks the
// echoed stream against a regenerated copy, and reports counts and a timeout.
module uart_echo_checker
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 50000000,
    parameter int unsigned BAUD_RATE       = 9600,
    parameter logic [7:0]  SEED            = 8'h01,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_BITS    = 40
) (
    input logic              clk,
    input logic              sresetn,
    uart_echo_checker_if.master bus
);

    localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF  = CPB / 2;
    localparam int unsigned CNT_W = $clog2(CPB + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_BITS + 1);
    localparam logic [CNT_W-1:0] CPB_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_BITS - 1);
    localparam logic [3:0]       MAX_OUT   = 4'(MAX_OUTSTANDING);

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_line_q, tx_line_d;
    logic             launch_c;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic             done_c;

    logic [7:0]       tx_lfsr_val, exp_lfsr_val;
    logic [3:0]       outstanding_q;
    logic             timeout_q;
    logic [CNT_W-1:0] to_cnt_q;
    logic [TO_W-1:0]  to_bits_q;
    logic [15:0]      tx_count_q, rx_count_q, err_count_q;
    logic [7:0]       last_exp_q, last_got_q;

    logic resync_c, dec_c, err_c;

    assign resync_c = !bus.en && (tx_state_q == TX_IDLE);
    assign dec_c    = done_c && (outstanding_q != 4'd0);
    assign err_c    = done_c && ((rx_shift_q != exp_lfsr_val) || !rx_sync_q || (outstanding_q == 4'd0));

    lfsr8 #(.SEED(SEED)) tx_lfsr (
        .clk(clk), .sresetn(sresetn), .advance(launch_c),
        .load(1'b0), .load_value(8'h00), .value(tx_lfsr_val)
    );

    lfsr8 #(.SEED(SEED)) exp_lfsr (
        .clk(clk), .sresetn(sresetn), .advance(done_c),
        .load(resync_c), .load_value(tx_lfsr_val), .value(exp_lfsr_val)
    );

    // FSM and datapath registers
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_meta_q  <= bus.serial_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
        end
    end

    // TX next state: line value is registered one step ahead of the state
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        launch_c   = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (bus.en && !timeout_q && (outstanding_q < MAX_OUT)) begin
                    launch_c   = 1'b1;
                    tx_shift_d = tx_lfsr_val;
                    tx_line_d  = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CPB_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CPB_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CPB_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX next state: mid-bit sampling, false-start rejection at half a bit
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        done_c     = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CPB_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CPB_LAST) begin
                    rx_cnt_d   = '0;
                    done_c     = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Outstanding tracking and echo timeout; en=0 while idle resynchronises
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            outstanding_q <= '0;
            timeout_q     <= 1'b0;
            to_cnt_q      <= '0;
            to_bits_q     <= '0;
        end else begin
            if (resync_c) begin
                outstanding_q <= '0;
            end else if (launch_c && !dec_c) begin
                outstanding_q <= outstanding_q + 4'd1;
            end else if (!launch_c && dec_c) begin
                outstanding_q <= outstanding_q - 4'd1;
            end

            if (resync_c) begin
                timeout_q <= 1'b0;
                to_cnt_q  <= '0;
                to_bits_q <= '0;
            end else if ((outstanding_q == 4'd0) || done_c) begin
                to_cnt_q  <= '0;
                to_bits_q <= '0;
            end else if (to_cnt_q == CPB_LAST) begin
                to_cnt_q <= '0;
                if (to_bits_q == TO_LAST) begin
                    timeout_q <= 1'b1;
                end else begin
                    to_bits_q <= to_bits_q + TO_W'(1);
                end
            end else begin
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            end
        end
    end

    // Status counters and last-error capture
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            tx_count_q  <= '0;
            rx_count_q  <= '0;
            err_count_q <= '0;
            last_exp_q  <= '0;
            last_got_q  <= '0;
        end else begin
            if (launch_c) tx_count_q <= sat_inc16(tx_count_q);
            if (done_c)   rx_count_q <= sat_inc16(rx_count_q);
            if (err_c) begin
                err_count_q <= sat_inc16(err_count_q);
                last_exp_q  <= exp_lfsr_val;
                last_got_q  <= rx_shift_q;
            end
        end
    end

    assign bus.serial_tx = tx_line_q;
    assign bus.tx_count  = tx_count_q;
    assign bus.rx_count  = rx_count_q;
    assign bus.err_count = err_count_q;
    assign bus.last_exp  = last_exp_q;
    assign bus.last_got  = last_got_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Directed bench for uart_echo_checker: loopback with planted bit/stop faults,
// stuck line timeout and resync, glitch rejection and mid-frame reset.
module tb_uart_echo_checker;

    logic clk = 1'b0;
    logic sresetn = 1'b0;
    uart_echo_checker_if bus();

    uart_echo_checker #(
        .CLK_FREQ(1000000), .BAUD_RATE(100000), .SEED(8'h01),
        .MAX_OUTSTANDING(4), .TIMEOUT_BITS(40)
    ) dut (
        .clk(clk), .sresetn(sresetn), .bus(bus)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic force_mode = 1'b1;
    logic force_val  = 1'b1;
    int   flip_frame = -1;
    int   flip_pos   = -1;
    logic flip;

    int         mon_cnt = 0;
    int         mon_frames = 0;
    logic       mon_busy = 1'b0;
    logic [7:0] mon_sh = 8'h00;
    logic [7:0] dec [0:255];

    logic [7:0] exp_seq [0:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};

    // Echo path with a per-bit fault window; position 0 is the start bit, 9 the stop bit
    always_comb flip = mon_busy && (mon_frames == flip_frame) && ((mon_cnt / 10) == flip_pos);
    assign bus.serial_rx = force_mode ? force_val : (bus.serial_tx ^ flip);

    // Independent 8N1 decoder on serial_tx, sampled at mid-bit on the falling clock edge
    always @(negedge clk) begin
        if (!mon_busy) begin
            if (bus.serial_tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
            end
        end else begin
            mon_cnt = mon_cnt + 1;
            if ((mon_cnt % 10 == 5) && (mon_cnt > 10) && (mon_cnt < 90))
                mon_sh = {bus.serial_tx, mon_sh[7:1]};
            if (mon_cnt == 99) begin
                dec[8'(mon_frames)] = mon_sh;
                mon_frames = mon_frames + 1;
                mon_busy   = 1'b0;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        sresetn = 1'b0;
        tick(2);
        sresetn = 1'b1;
        tick(2);
    endtask

    int base;

    initial begin
        bus.en = 1'b0;
        tick(3);
        check("rst_tx_line", 32'(bus.serial_tx), 32'd1);
        check("rst_tx_count", 32'(bus.tx_count), 32'd0);
        check("rst_rx_count", 32'(bus.rx_count), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_last_exp", 32'(bus.last_exp), 32'd0);
        check("rst_last_got", 32'(bus.last_got), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        sresetn = 1'b1;
        tick(2);

        // Clean loopback
        force_mode = 1'b0;
        base = mon_frames;
        bus.en = 1'b1;
        tick(2000);
        bus.en = 1'b0;
        tick(300);
        for (int i = 0; i < 8; i++)
            check($sformatf("loop_byte%0d", i), 32'(dec[8'(base + i)]), 32'(exp_seq[i]));
        check("loop_rx_min", 32'(bus.rx_count >= 16'd18), 32'd1);
        check("loop_tx_count", 32'(bus.tx_count), 32'(mon_frames - base));
        check("loop_rx_count", 32'(bus.rx_count), 32'(mon_frames - base));
        check("loop_err", 32'(bus.err_count), 32'd0);
        check("loop_timeout", 32'(bus.timeout), 32'd0);

        // Bit 3 of the third echoed byte inverted
        do_reset();
        base = mon_frames;
        flip_frame = base + 2;
        flip_pos = 4;
        bus.en = 1'b1;
        tick(1500);
        bus.en = 1'b0;
        tick(300);
        flip_frame = -1;
        check("bit_err_count", 32'(bus.err_count), 32'd1);
        check("bit_last_exp", 32'(bus.last_exp), 32'h04);
        check("bit_last_got", 32'(bus.last_got), 32'h0C);
        check("bit_rx_count", 32'(bus.rx_count), 32'(mon_frames - base));

        // Stop bit of the second echoed byte forced low
        do_reset();
        base = mon_frames;
        flip_frame = base + 1;
        flip_pos = 9;
        bus.en = 1'b1;
        tick(1000);
        bus.en = 1'b0;
        tick(300);
        flip_frame = -1;
        check("stop_err_count", 32'(bus.err_count), 32'd1);
        check("stop_last_exp", 32'(bus.last_exp), 32'h02);
        check("stop_last_got", 32'(bus.last_got), 32'h02);
        check("stop_rx_count", 32'(bus.rx_count), 32'(mon_frames - base));

        // Echo line stuck high: launches stall at MAX_OUTSTANDING, then timeout
        do_reset();
        force_mode = 1'b1;
        force_val = 1'b1;
        bus.en = 1'b1;
        tick(350);
        check("stuck_tx_count", 32'(bus.tx_count), 32'd4);
        check("stuck_no_timeout", 32'(bus.timeout), 32'd0);
        tick(250);
        check("stuck_timeout", 32'(bus.timeout), 32'd1);
        check("stuck_tx_hold", 32'(bus.tx_count), 32'd4);
        check("stuck_rx_count", 32'(bus.rx_count), 32'd0);
        bus.en = 1'b0;
        tick(3);
        check("resync_timeout_clr", 32'(bus.timeout), 32'd0);
        force_mode = 1'b0;
        base = mon_frames;
        bus.en = 1'b1;
        tick(1000);
        bus.en = 1'b0;
        tick(300);
        check("resync_first_byte", 32'(dec[8'(base)]), 32'h11);
        check("resync_err", 32'(bus.err_count), 32'd0);
        check("resync_rx_count", 32'(bus.rx_count), 32'(mon_frames - base));

        // Short low glitch on the echo line
        do_reset();
        force_mode = 1'b1;
        force_val = 1'b0;
        tick(3);
        force_val = 1'b1;
        tick(100);
        check("glitch_rx_count", 32'(bus.rx_count), 32'd0);
        check("glitch_err", 32'(bus.err_count), 32'd0);

        // Reset in the middle of a data bit
        do_reset();
        force_mode = 1'b0;
        bus.en = 1'b1;
        tick(35);
        check("midrst_pre_tx_count", 32'(bus.tx_count), 32'd1);
        check("midrst_pre_line", 32'(bus.serial_tx), 32'd0);
        sresetn = 1'b0;
        #1;
        check("midrst_line", 32'(bus.serial_tx), 32'd1);
        check("midrst_tx_count", 32'(bus.tx_count), 32'd0);
        bus.en = 1'b0;
        tick(2);
        sresetn = 1'b1;
        tick(120);
        base = mon_frames;
        bus.en = 1'b1;
        tick(150);
        bus.en = 1'b0;
        check("midrst_tx_count2", 32'(bus.tx_count), 32'd2);
        tick(150);
        check("midrst_first_byte", 32'(dec[8'(base)]), 32'h01);
        check("midrst_err", 32'(bus.err_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_echo_checker.md
# uart_echo_checker

Self-checking UART traffic source and echo checker: the far-end partner of the board's UART loopback design. It transmits a pseudo-random byte stream on its serial output, receives the echoed stream on its serial input and compares each returned byte against a regenerated copy of the sent sequence. It sits in bench tops and in a second FPGA's link-test image, with counters and flags wired to LEDs or a status register.

## Interface
- CLK_FREQ, 50000000: clock frequency in Hz.
- BAUD_RATE, 9600: line rate; 8N1 framing, LSB first.
- SEED, 8'h01: LFSR seed; must be non-zero.
- MAX_OUTSTANDING, 4: maximum number of bytes sent but not yet returned (1..15).
- TIMEOUT_BITS, 40: bit periods with no returned byte while outstanding > 0 before a timeout.
- clk  in  1  single clock.
- sresetn  in  1  asynchronous, active-low reset.
- en  in  1  run enable; sampled only between frames.
- serial_rx  in  1  echoed line (asynchronous, idle high).
- serial_tx  out  1  transmit line, idle high.
- tx_count  out  16  bytes launched, saturating.
- rx_count  out  16  bytes received (including bad ones), saturating.
- err_count  out  16  data mismatches plus framing errors, saturating.
- last_exp / last_got  out  8 each  expected and received byte of the most recent error.
- timeout  out  1  sticky; set on echo timeout.

## Operation
- CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division); HALF = CLKS_PER_BIT / 2.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, period 255. tx_lfsr and exp_lfsr both reset to SEED.
- TX FSM (TX_IDLE, TX_START, TX_DATA, TX_STOP):
  - TX_IDLE to TX_START when en=1, timeout=0 and outstanding < MAX_OUTSTANDING. The byte sent is the current tx_lfsr value. tx_lfsr advances and tx_count increments in the same cycle.
  - Each state holds the line for CLKS_PER_BIT cycles.
  - TX_DATA shifts out 8 bits, LSB first.
  - TX_STOP drives 1, then returns to TX_IDLE. Back-to-back frames are allowed.
- RX FSM (RX_IDLE, RX_START, RX_DATA, RX_STOP):
  - serial_rx passes through a 2-flop synchroniser.
  - RX_IDLE to RX_START on a synchronised 1-to-0 edge.
  - RX_START: at HALF, re-checks the line. If it is 1, this is a false start: go to RX_IDLE with no count.
  - RX_DATA samples 8 bits at CLKS_PER_BIT intervals.
  - RX_STOP samples the stop bit, then goes to RX_IDLE.
- Byte completion (the cycle the stop bit is sampled):
  - rx_count increments and exp_lfsr advances.
  - An error is recorded if got != exp_lfsr or the stop bit is 0. Recording an error increments err_count and latches last_exp/last_got.
- outstanding = 4-bit counter. It increments on launch and decrements on completion; when both happen in the same cycle it is unchanged. It never decrements below 0: a byte received with outstanding=0 is counted in rx_count and as an error.
- Timeout:
  - A bit-period counter runs while outstanding > 0. It clears on each completion.
  - On reaching TIMEOUT_BITS it sets timeout=1, which stops further launches.
  - en=0 with TX_IDLE clears timeout and outstanding and resets exp_lfsr to tx_lfsr. This resynchronises without a reset.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: serial_tx=1, all counts 0, last_exp/last_got=0, timeout=0, both FSMs idle, LFSRs=SEED.
- Reset asserted mid-frame: serial_tx goes to 1 asynchronously and the frame is abandoned.
- First start bit: serial_tx falls 1 cycle after the cycle in which en=1 is sampled in TX_IDLE.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- RX completion occurs 2 (synchroniser) + HALF + 9·CLKS_PER_BIT cycles after the falling edge on serial_rx. Counters and flags update on the following clock edge.
- en deasserted mid-frame: the current frame completes and no new frame starts.

## Structure
- Package uart_pkg holds:
  - the clks_per_bit(CLK_FREQ, BAUD_RATE) function;
  - the tx_state_t and rx_state_t enums;
  - the LFSR tap constant.
- Sub-module lfsr8 (seed parameter, advance strobe, 8-bit value), instantiated twice: tx_lfsr and exp_lfsr.

## Test plan
All scenarios use CLK_FREQ=1000000, BAUD_RATE=100000 (CLKS_PER_BIT=10).
- serial_tx wired to serial_rx, en=1 for 2000 cycles -> serial_tx frames decode to the LFSR sequence starting 8'h01; rx_count ≥ 18; err_count=0; timeout=0.
- Same loop with bit 3 of the third echoed byte inverted in the path -> err_count=1; last_got = last_exp ^ 8'h08; later bytes are clean.
- Stop bit of the second echoed byte forced to 0 -> err_count=1; rx_count still increments.
- serial_rx tied high, en=1 -> tx_count stops at 4; after 40 bit periods timeout=1; then en=0 followed by loop restored -> timeout clears and new bytes check clean.
- 3-cycle low glitch on serial_rx -> no rx_count change (false start).
- sresetn pulsed low during TX_DATA -> serial_tx=1 immediately; all counts 0; next frame sends 8'h01.
